goertzel_frame_ctrl: RTL and testbench
======================================

# goertzel_frame_ctrl

Frame sequencer for the multi-bin Goertzel engine. It latches a per-frame configuration, clears the engine, paces a ready/valid sample stream into the engine's single-pulse `en`/`data_i` input, and waits for all bin `valid` flags. It then presents the NF packed magnitudes through a result handshake. It sits between the sample source/CSR layer and the engine instance, and owns the engine's reset and enable.

## Interface
- `NF`, 11, number of bins (width of engine `valid`).
- `DW`, 64, sample/coefficient width, 32.32 signed.
- `GAP`, 8, minimum cycles between engine `en` pulses (≥ multiplier latency + 2).
- `TMO`, 4096, watchdog cycles allowed in WAIT (used only with the macro).

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  frame start pulse; sampled only in IDLE.
- `cfg_ns`  in  32  samples per frame (32.0); latched on accepted `start`.
- `cfg_ns_coef`  in  DW  normalisation coefficient (32.32); latched on accepted `start`.
- `s_valid`  in  1  sample valid.
- `s_data`  in  DW  sample (32.32).
- `s_ready`  out  1  sample accept.
- `eng_rstn`  out  1  engine reset, active-low.
- `eng_en`  out  1  one-cycle sample strobe to engine.
- `eng_data`  out  DW  sample to engine, valid with `eng_en`.
- `eng_ns`  out  32  latched `cfg_ns`.
- `eng_ns_coef`  out  DW  latched `cfg_ns_coef`.
- `eng_valid`  in  NF  engine per-bin valid.
- `eng_res`  in  NF*32  engine magnitudes (16.16, bin 0 in LSBs).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  NF*32  latched magnitudes.
- `busy`  out  1  high in every state except IDLE.
- `err_tmo`  out  1  sticky watchdog flag; cleared by accepted `start` (macro only, else tied 0).

## Operation
- States: IDLE → CLR → FEED → WAIT → OUT → IDLE.
- IDLE: `s_ready`=0. An accepted `start` latches the config, sets `sent`=0, and moves to CLR.
- CLR: `eng_rstn`=0 for exactly 2 cycles, then FEED.
- FEED: `s_ready`=1 iff `gap_cnt`==0 and `sent`<`eng_ns`.
  - On handshake: register `eng_data`=`s_data`, pulse `eng_en` for 1 cycle, load `gap_cnt`=GAP-1, increment `sent`.
  - `gap_cnt` decrements to 0 and saturates there.
  - When `sent`==`eng_ns` and `gap_cnt`==0, go to WAIT.
  - `cfg_ns`=0: FEED lasts one cycle with `s_ready`=0, then WAIT.
- WAIT: when `&eng_valid`=1, register `eng_res` into `res_data` and go to OUT.
- OUT: `res_valid`=1. `res_data` is held stable until `res_ready`. On `res_valid&res_ready`, go to IDLE.
- `start` outside IDLE is ignored. `cfg_*` changes outside IDLE have no effect.
- `sent` is a 32-bit counter. It never wraps because FEED stops at `eng_ns`.
- Partial `eng_valid` is never accepted; all NF bits are required.

## Timing
- Reset values: `s_ready`=0, `eng_rstn`=0, `eng_en`=0, `eng_data`=0, `eng_ns`=0, `eng_ns_coef`=0, `res_valid`=0, `res_data`=0, `busy`=0, `err_tmo`=0, state IDLE.
  - `eng_rstn` rises 1 cycle after `rst` deasserts, keeping the engine held while `rst` is high.
- `start` at cycle t: `busy`=1 and `eng_rstn`=0 at t+1 and t+2. FEED and `eng_rstn`=1 at t+3. Earliest `s_ready` at t+3.
- Sample handshake at cycle h: `eng_en`=1 at h+1. Next `s_ready` no earlier than h+GAP. Sustained rate is 1 sample per GAP cycles.
- `&eng_valid` at cycle v: `res_valid`=1 at v+1.
- Handshake at cycle r: state IDLE at r+1. A `start` at r+1 is accepted.
- `rst` mid-frame: all outputs return to reset values asynchronously. The in-flight frame is discarded and `eng_rstn` is driven low immediately.

## Configuration
- `GZ_CTRL_TIMEOUT_EN` defined: a WAIT cycle counter runs.
  - Reaching TMO cycles without `&eng_valid` sets `err_tmo`=1 and drives `eng_rstn`=0 for 1 cycle, then IDLE. No result is produced.
- `GZ_CTRL_TIMEOUT_EN` undefined: no counter. WAIT exits only on `&eng_valid`. `err_tmo` is tied 0 and `TMO` is unused.

## Test plan
- Reset then `start` with `cfg_ns`=4, GAP=8, `s_valid` held 1 → 4 `eng_en` pulses spaced exactly 8 cycles, then WAIT. Forcing `eng_valid`=all-ones gives `res_valid` the next cycle, `res_data`=`eng_res`.
- `cfg_ns`=3 with `s_valid` toggling 1-cycle-on/3-off → exactly 3 handshakes, `eng_data` matching each `s_data`, no `eng_en` without a handshake.
- `cfg_ns`=0 → no `s_ready`, state reaches WAIT 4 cycles after `start`.
- `res_ready`=0 for 20 cycles with `eng_res` changing → `res_data` stable. `start` pulses during OUT are ignored. `res_ready`=1 returns IDLE the next cycle.
- `eng_valid`=0x7FE (one bin missing) → stays in WAIT. With the macro, `err_tmo`=1 after TMO cycles and return to IDLE. A following `start` clears `err_tmo`.
- `rst` pulsed mid-FEED after 2 samples → all outputs at reset values. A fresh `start` feeds a full `cfg_ns` samples.

Source files
------------

// File: rtl/goertzel_frame_ctrl_if.sv
// rtl/goertzel_frame_ctrl_if.sv - sample, engine and result bus bundle for goertzel_frame_ctrl
interface goertzel_frame_ctrl_if #(
    parameter int NF = 11,
    parameter int DW = 64
);
    logic                 start;
    logic [31:0]          cfg_ns;
    logic [DW-1:0]        cfg_ns_coef;
    logic                 s_valid;
    logic [DW-1:0]        s_data;
    logic                 s_ready;
    logic                 eng_rstn;
    logic                 eng_en;
    logic [DW-1:0]        eng_data;
    logic [31:0]          eng_ns;
    logic [DW-1:0]        eng_ns_coef;
    logic [NF-1:0]        eng_valid;
    logic [NF*32-1:0]     eng_res;
    logic                 res_valid;
    logic                 res_ready;
    logic [NF*32-1:0]     res_data;
    logic                 busy;
    logic                 err_tmo;

    // controller side
    modport slave (
        input  start, cfg_ns, cfg_ns_coef, s_valid, s_data, eng_valid, eng_res, res_ready,
        output s_ready, eng_rstn, eng_en, eng_data, eng_ns, eng_ns_coef,
        output res_valid, res_data, busy, err_tmo
    );

    // environment side: sample source, CSR layer, engine and result sink
    modport master (
        output start, cfg_ns, cfg_ns_coef, s_valid, s_data, eng_valid, eng_res, res_ready,
        input  s_ready, eng_rstn, eng_en, eng_data, eng_ns, eng_ns_coef,
        input  res_valid, res_data, busy, err_tmo
    );
endinterface

// File: rtl/goertzel_frame_ctrl.sv
// rtl/goertzel_frame_ctrl.sv - Goertzel frame sequencer, optional WAIT watchdog under GZ_CTRL_TIMEOUT_EN
module goertzel_frame_ctrl #(
    parameter int NF  = 11,
    parameter int DW  = 64,
    parameter int GAP = 8,
    parameter int TMO = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    goertzel_frame_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_FEED = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [2:0]       r_state;
    logic             r_clr_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [31:0]      r_sent;
    logic [31:0]      r_eng_ns;
    logic [DW-1:0]    r_eng_ns_coef;
    logic [DW-1:0]    r_eng_data;
    logic             r_eng_en;
    logic             r_eng_rstn;
    logic [NF*32-1:0] r_res_data;
    logic             w_s_ready;
    logic             w_all_valid;

`ifdef GZ_CTRL_TIMEOUT_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    logic [TW-1:0]    r_tmo_cnt;
    logic             r_err_tmo;
`else
    logic             w_unused_tmo;
    assign w_unused_tmo = (TMO > 0);
`endif

    // a sample is accepted only once the pacing gap has elapsed and the frame is not yet full
    assign w_s_ready   = (r_state == S_FEED) && (r_gap_cnt == '0) && (r_sent < r_eng_ns);
    // a result is only complete when every bin reports valid
    assign w_all_valid = &bus.eng_valid;

    assign bus.s_ready     = w_s_ready;
    assign bus.eng_rstn    = r_eng_rstn;
    assign bus.eng_en      = r_eng_en;
    assign bus.eng_data    = r_eng_data;
    assign bus.eng_ns      = r_eng_ns;
    assign bus.eng_ns_coef = r_eng_ns_coef;
    assign bus.res_valid   = (r_state == S_OUT);
    assign bus.res_data    = r_res_data;
    assign bus.busy        = (r_state != S_IDLE);
`ifdef GZ_CTRL_TIMEOUT_EN
    assign bus.err_tmo     = r_err_tmo;
`else
    assign bus.err_tmo     = 1'b0;
`endif

    // frame sequencing: config latch, engine clear, paced feed, result capture and hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_clr_cnt     <= 1'b0;
            r_gap_cnt     <= '0;
            r_sent        <= '0;
            r_eng_ns      <= '0;
            r_eng_ns_coef <= '0;
            r_eng_data    <= '0;
            r_eng_en      <= 1'b0;
            r_eng_rstn    <= 1'b0;
            r_res_data    <= '0;
`ifdef GZ_CTRL_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_err_tmo     <= 1'b0;
`endif
        end else begin
            r_eng_en <= 1'b0;
            if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    // engine leaves reset one cycle after any reset or watchdog abort
                    r_eng_rstn <= 1'b1;
                    if (bus.start) begin
                        r_eng_ns      <= bus.cfg_ns;
                        r_eng_ns_coef <= bus.cfg_ns_coef;
                        r_sent        <= '0;
                        r_gap_cnt     <= '0;
                        r_clr_cnt     <= 1'b0;
                        r_eng_rstn    <= 1'b0;
                        r_state       <= S_CLR;
`ifdef GZ_CTRL_TIMEOUT_EN
                        r_err_tmo     <= 1'b0;
`endif
                    end
                end
                S_CLR: begin
                    if (r_clr_cnt) begin
                        r_eng_rstn <= 1'b1;
                        r_state    <= S_FEED;
                    end else begin
                        r_clr_cnt  <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (w_s_ready && bus.s_valid) begin
                        r_eng_data <= bus.s_data;
                        r_eng_en   <= 1'b1;
                        r_gap_cnt  <= GW'(GAP - 1);
                        r_sent     <= r_sent + 32'd1;
                    end else if ((r_sent == r_eng_ns) && (r_gap_cnt == '0)) begin
                        r_state    <= S_WAIT;
`ifdef GZ_CTRL_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (w_all_valid) begin
                        r_res_data <= bus.eng_res;
                        r_state    <= S_OUT;
                    end
`ifdef GZ_CTRL_TIMEOUT_EN
                    else if (r_tmo_cnt == TW'(TMO - 1)) begin
                        r_err_tmo  <= 1'b1;
                        r_eng_rstn <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tmo_cnt  <= r_tmo_cnt + TW'(1);
                    end
`endif
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// tb/tb_goertzel_frame_ctrl.sv - scoreboard bench for goertzel_frame_ctrl
module tb_goertzel_frame_ctrl;
    localparam int NF  = 11;
    localparam int DW  = 64;
    localparam int GAP = 8;
    localparam int TMO = 64;
    localparam int OW  = 6 + 32 + 2*DW + NF*32;
    localparam logic [NF-1:0] ALL_V = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0]    exp_data[$];
    logic [NF*32-1:0] exp_res[$];

    goertzel_frame_ctrl_if #(.NF(NF), .DW(DW)) bus ();

    goertzel_frame_ctrl #(.NF(NF), .DW(DW), .GAP(GAP), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OW-1:0] outs();
        return {bus.s_ready, bus.eng_rstn, bus.eng_en, bus.eng_data, bus.eng_ns, bus.eng_ns_coef,
                bus.res_valid, bus.res_data, bus.busy, bus.err_tmo};
    endfunction

    function automatic logic [NF*32-1:0] rand_res();
        logic [NF*32-1:0] r;
        for (int i = 0; i < NF; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", outs());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.eng_rstn !== 1'b0) begin
            errors++; $display("FAIL reset_rstn_hold got=%b exp=0", bus.eng_rstn);
        end
        @(negedge clk);
        checks++;
        if (bus.eng_rstn !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_rstn_rise rstn=%b busy=%b exp rstn=1 busy=0", bus.eng_rstn, bus.busy);
        end
    endtask

    task automatic test_basic_feed;
        int t, n_en, n_hs, first_en, prev_en;
        logic [DW-1:0] got;
        logic [NF*32-1:0] r;
        n_en = 0; n_hs = 0; first_en = -1; prev_en = -1;
        @(negedge clk);
        bus.cfg_ns = 32'd4; bus.cfg_ns_coef = 64'h0000_0001_4000_0000;
        bus.start = 1'b1; bus.s_valid = 1'b1; bus.s_data = {$urandom, $urandom};
        t = cyc;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.cfg_ns = 32'd9;
            bus.cfg_ns_coef = 64'hdead_beef_0000_0000;
            if (cyc == t+1 || cyc == t+2) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.eng_rstn !== 1'b0) begin
                    errors++; $display("FAIL basic_clr cyc=%0d busy=%b rstn=%b exp busy=1 rstn=0", cyc-t, bus.busy, bus.eng_rstn);
                end
            end
            if (cyc == t+3) begin
                checks++;
                if (bus.eng_rstn !== 1'b1 || bus.s_ready !== 1'b1) begin
                    errors++; $display("FAIL basic_feed_entry rstn=%b s_ready=%b exp 1 1", bus.eng_rstn, bus.s_ready);
                end
            end
            if (bus.eng_en === 1'b1) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++; $display("FAIL basic_en_unexpected got eng_en=1 exp no pulse");
                end else begin
                    got = exp_data.pop_front();
                    if (bus.eng_data !== got) begin
                        errors++; $display("FAIL basic_eng_data got=%h exp=%h", bus.eng_data, got);
                    end
                end
                if (prev_en >= 0) begin
                    checks++;
                    if (cyc - prev_en != GAP) begin
                        errors++; $display("FAIL basic_spacing got=%0d exp=%0d", cyc - prev_en, GAP);
                    end
                end
                if (first_en < 0) first_en = cyc;
                prev_en = cyc;
                n_en++;
            end
            bus.s_data = {$urandom, $urandom};
            if (bus.s_valid && bus.s_ready) begin
                exp_data.push_back(bus.s_data);
                n_hs++;
            end
        end
        checks++;
        if (n_en != 4 || n_hs != 4 || first_en != t+4) begin
            errors++; $display("FAIL basic_count en=%0d hs=%0d first=%0d exp 4 4 %0d", n_en, n_hs, first_en - t, 4);
        end
        checks++;
        if (bus.eng_ns !== 32'd4 || bus.eng_ns_coef !== 64'h0000_0001_4000_0000) begin
            errors++; $display("FAIL basic_cfg_latch ns=%0d coef=%h exp 4 0000000140000000", bus.eng_ns, bus.eng_ns_coef);
        end
        bus.s_valid = 1'b0;
        r = rand_res();
        bus.eng_res = r; bus.eng_valid = ALL_V;
        exp_res.push_back(r);
        @(negedge clk);
        checks++;
        r = exp_res.pop_front();
        if (bus.res_valid !== 1'b1 || bus.res_data !== r) begin
            errors++; $display("FAIL basic_result valid=%b data=%h exp valid=1 data=%h", bus.res_valid, bus.res_data, r);
        end
        bus.eng_valid = '0; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL basic_release busy=%b res_valid=%b exp 0 0", bus.busy, bus.res_valid);
        end
    endtask

    task automatic test_sparse_valid;
        int n_en, n_hs;
        logic [DW-1:0] got;
        logic [NF*32-1:0] r;
        n_en = 0; n_hs = 0;
        @(negedge clk);
        bus.cfg_ns = 32'd3; bus.start = 1'b1; bus.s_valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.eng_en === 1'b1) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++; $display("FAIL sparse_en_unexpected got eng_en=1 exp no pulse");
                end else begin
                    got = exp_data.pop_front();
                    if (bus.eng_data !== got) begin
                        errors++; $display("FAIL sparse_eng_data got=%h exp=%h", bus.eng_data, got);
                    end
                end
                n_en++;
            end
            bus.s_valid = (k % 4 == 0);
            bus.s_data = {$urandom, $urandom};
            if (bus.s_valid && bus.s_ready) begin
                exp_data.push_back(bus.s_data);
                n_hs++;
            end
        end
        bus.s_valid = 1'b0;
        checks++;
        if (n_en != 3 || n_hs != 3 || exp_data.size() != 0) begin
            errors++; $display("FAIL sparse_count en=%0d hs=%0d left=%0d exp 3 3 0", n_en, n_hs, exp_data.size());
        end
        r = rand_res();
        bus.eng_res = r; bus.eng_valid = ALL_V;
        exp_res.push_back(r);
        @(negedge clk);
        checks++;
        r = exp_res.pop_front();
        if (bus.res_valid !== 1'b1 || bus.res_data !== r) begin
            errors++; $display("FAIL sparse_result valid=%b data=%h exp valid=1 data=%h", bus.res_valid, bus.res_data, r);
        end
        bus.eng_valid = '0; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int t;
        logic [NF*32-1:0] r, r2;
        @(negedge clk);
        r = rand_res();
        bus.cfg_ns = 32'd0; bus.start = 1'b1; bus.eng_valid = ALL_V; bus.eng_res = r;
        exp_res.push_back(r);
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (bus.s_ready !== 1'b0 || bus.res_valid !== (cyc >= t+5)) begin
                errors++; $display("FAIL zero_ns cyc=%0d s_ready=%b res_valid=%b exp 0 %b", cyc-t, bus.s_ready, bus.res_valid, cyc >= t+5);
            end
        end
        r = exp_res.pop_front();
        for (int k = 0; k < 20; k++) begin
            bus.res_ready = 1'b0;
            bus.start = k[0];
            bus.cfg_ns = 32'd7;
            bus.eng_res = rand_res();
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== r) begin
                errors++; $display("FAIL hold_stable k=%0d valid=%b data=%h exp valid=1 data=%h", k, bus.res_valid, bus.res_data, r);
            end
        end
        bus.start = 1'b0; bus.res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release busy=%b res_valid=%b exp 0 0", bus.busy, bus.res_valid);
        end
        r2 = rand_res();
        bus.res_ready = 1'b0; bus.start = 1'b1; bus.cfg_ns = 32'd0; bus.eng_res = r2;
        exp_res.push_back(r2);
        t = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.eng_rstn !== 1'b0) begin
            errors++; $display("FAIL b2b_accept busy=%b rstn=%b exp 1 0", bus.busy, bus.eng_rstn);
        end
        while (cyc < t+5) @(negedge clk);
        checks++;
        r2 = exp_res.pop_front();
        if (bus.res_valid !== 1'b1 || bus.res_data !== r2 || bus.eng_ns !== 32'd0) begin
            errors++; $display("FAIL b2b_result valid=%b ns=%0d data=%h exp valid=1 ns=0 data=%h", bus.res_valid, bus.eng_ns, bus.res_data, r2);
        end
        bus.eng_valid = '0; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_partial_valid;
        int t;
        bit saw_res;
        saw_res = 1'b0;
        @(negedge clk);
        bus.cfg_ns = 32'd0; bus.start = 1'b1; bus.eng_valid = 11'h7FE;
        t = cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.res_valid === 1'b1) saw_res = 1'b1;
        end
        checks++;
        if (saw_res || bus.busy !== 1'b1) begin
            errors++; $display("FAIL partial_wait saw_res=%b busy=%b exp 0 1", saw_res, bus.busy);
        end
`ifdef GZ_CTRL_TIMEOUT_EN
        for (int k = 0; k < TMO + 40 && bus.busy === 1'b1; k++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) saw_res = 1'b1;
        end
        checks++;
        if (cyc != t + 4 + TMO || bus.err_tmo !== 1'b1 || bus.eng_rstn !== 1'b0 || saw_res) begin
            errors++; $display("FAIL tmo_abort at=%0d err=%b rstn=%b res=%b exp at=%0d err=1 rstn=0 res=0", cyc-t, bus.err_tmo, bus.eng_rstn, saw_res, 4+TMO);
        end
        bus.eng_valid = '0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.err_tmo !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL tmo_clear err=%b busy=%b exp 0 1", bus.err_tmo, bus.busy);
        end
`else
        checks++;
        if (bus.err_tmo !== 1'b0) begin
            errors++; $display("FAIL tmo_tied got=%b exp=0", bus.err_tmo);
        end
`endif
        bus.eng_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_feed;
        int n_en;
        logic [DW-1:0] got;
        logic [NF*32-1:0] r;
        n_en = 0;
        @(negedge clk);
        bus.cfg_ns = 32'd5; bus.start = 1'b1; bus.s_valid = 1'b1;
        for (int k = 0; k < 60 && n_en < 2; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.eng_en === 1'b1) n_en++;
            if (n_en < 2) bus.s_data = {$urandom, $urandom};
        end
        checks++;
        if (n_en != 2) begin
            errors++; $display("FAIL rst_mid_setup en=%0d exp 2", n_en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got=%h exp=0", outs());
        end
        exp_data.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_en = 0;
        bus.start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.eng_en === 1'b1) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++; $display("FAIL refeed_en_unexpected got eng_en=1 exp no pulse");
                end else begin
                    got = exp_data.pop_front();
                    if (bus.eng_data !== got) begin
                        errors++; $display("FAIL refeed_eng_data got=%h exp=%h", bus.eng_data, got);
                    end
                end
                n_en++;
            end
            bus.s_data = {$urandom, $urandom};
            if (bus.s_valid && bus.s_ready) exp_data.push_back(bus.s_data);
        end
        bus.s_valid = 1'b0;
        checks++;
        if (n_en != 5 || exp_data.size() != 0) begin
            errors++; $display("FAIL refeed_count en=%0d left=%0d exp 5 0", n_en, exp_data.size());
        end
        r = rand_res();
        bus.eng_res = r; bus.eng_valid = ALL_V;
        exp_res.push_back(r);
        @(negedge clk);
        checks++;
        r = exp_res.pop_front();
        if (bus.res_valid !== 1'b1 || bus.res_data !== r) begin
            errors++; $display("FAIL refeed_result valid=%b data=%h exp valid=1 data=%h", bus.res_valid, bus.res_data, r);
        end
        bus.eng_valid = '0; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.cfg_ns = '0; bus.cfg_ns_coef = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        bus.eng_valid = '0; bus.eng_res = '0; bus.res_ready = 1'b0;
        test_reset();
        test_basic_feed();
        test_sparse_valid();
        test_back_to_back();
        test_partial_valid();
        test_reset_mid_feed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
